tpu_tile_ctrl: RTL
==================

Name: tpu_tile_ctrl

Overview:
Parametrised next-generation TPU sequencer. It runs a configurable number of matrix tiles back to back through the systolic array. For each tile it streams SRAM read addresses, times the array's drain, reads out accumulator rows, then quantizes them with a runtime shift, rounding and saturation. Results go to a configurable number of rotating output SRAM banks, and a start/busy/done handshake replaces the fixed-length controller plus separate quantize/write-out stages.

Parameters:
ARRAY_SIZE, 16, systolic array dimension (rows and lanes per row)
ACC_WIDTH, 21, signed accumulator width per lane
OUTPUT_DATA_WIDTH, 16, signed quantized output width per lane
RADDR_WIDTH, 10, input SRAM read address width
WADDR_WIDTH, 6, output SRAM write address width
NUM_OUT_BANKS, 3, number of output SRAM banks (>=1)
TILE_WIDTH, 4, width of the tile-count configuration

Ports:
clk  input  1  clock
srst  input  1  synchronous active-high reset
start  input  1  one-cycle start request; ignored while busy
cfg_num_tiles  input  TILE_WIDTH  tiles to run; sampled on accepted start
cfg_k_len  input  9  load cycles per tile; sampled on start; 0 treated as 1
cfg_shift  input  5  arithmetic right shift for quantization; sampled on start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at job end
sram_raddr  output  RADDR_WIDTH  read address shared by all weight/data banks
alu_clear  output  1  one-cycle pulse clearing array accumulators at tile start
alu_start  output  1  high during LOAD (array consumes operands)
row_sel  output  log2(ARRAY_SIZE)  accumulator row presented by the array
acc_data  input  ARRAY_SIZE*ACC_WIDTH  row row_sel accumulators, combinational from array, lane 0 in LSBs
wr_en  output  NUM_OUT_BANKS  one-hot bank write enable
waddr  output  WADDR_WIDTH  output write address
wdata  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH  quantized row, lane 0 in LSBs

Behaviour:
- Reset (srst=1 at a clk edge): state IDLE; busy=0, done=0, sram_raddr=0, alu_clear=0, alu_start=0, row_sel=0, wr_en=0, waddr=0, wdata=0. Reset mid-job aborts immediately; no further writes.
- FSM states: IDLE, CLEAR, LOAD, DRAIN, WRITE, NEXT, FIN.
- IDLE: start=1 latches cfg_* and clears tile_idx=0 and sram_raddr=0.
  - If cfg_num_tiles==0 -> FIN.
  - Otherwise -> CLEAR.
- CLEAR (1 cycle): alu_clear=1 -> LOAD.
- LOAD (k_len cycles): alu_start=1; sram_raddr increments by 1 every LOAD cycle and wraps mod 2^RADDR_WIDTH. The address is NOT reset between tiles; tile t continues where tile t-1 ended. Exit to DRAIN.
- DRAIN (2*ARRAY_SIZE-1 cycles): all strobes low -> WRITE.
- WRITE (ARRAY_SIZE cycles): row_sel = 0..ARRAY_SIZE-1, one row per cycle. acc_data is sampled the same cycle, quantized and registered, so each write appears one cycle later: wr_en, waddr, wdata are registered.
- Write targets:
  - bank = tile_idx mod NUM_OUT_BANKS
  - waddr = (tile_idx / NUM_OUT_BANKS)*ARRAY_SIZE + row, truncated to WADDR_WIDTH
- NEXT (1 cycle): the last row's write occurs this cycle. tile_idx++; if tile_idx==num_tiles -> FIN, else CLEAR.
- FIN (1 cycle): done=1, busy deasserts the same cycle -> IDLE.
- Start pulses while busy are dropped. A start in the FIN cycle is dropped; start is accepted from IDLE only.
- Quantization, per lane, in ACC_WIDTH+1 bits:
  - r = acc + (shift>0 ? 2^(shift-1) : 0), i.e. round-half-up
  - q = r >>> shift (arithmetic)
  - saturate to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1]
  - shift >= ACC_WIDTH gives q = 0 or -1 per sign.
- Tile cycle count: 1 + k_len + 2*ARRAY_SIZE-1 + ARRAY_SIZE + 1.

Optional Feature:
TPU_SAT_CNT_EN:
- Defined: adds output sat_count (16 bits), reset 0, cleared on accepted start. It increments by the number of lanes that saturated in each written row, and sticks at 16'hFFFF.
- Undefined: port and logic absent; quantization behaviour is identical.

Test Plan:
- Reset then start with num_tiles=1, k_len=4, shift=0, array returning acc=row*16+lane:
  - sram_raddr steps 1..4 during LOAD
  - 16 writes on wr_en=3'b001 at waddr 0..15 with wdata lanes equal to row*16+lane
  - done pulses exactly 1+4+31+16+1+1 cycles after start.
- num_tiles=5, NUM_OUT_BANKS=3:
  - bank order a,b,c,a,b
  - tiles 3 and 4 write waddr 16..31
  - sram_raddr continuous (tile 1 starts at k_len)
  - one done pulse.
- Quantize with shift=4, acc=24 -> 2 (24+8=32, 32>>4); acc=-24 -> -1 (-24+8=-16, -16>>4); acc=2^20-1 -> 32767 saturated; acc=-2^20 -> -32768 saturated. With TPU_SAT_CNT_EN, sat_count=2 after the row.
- start held high during the entire job and asserted again in the FIN cycle -> exactly one job, no restart; cfg changes mid-job have no effect.
- num_tiles=0 -> no wr_en, busy high one cycle, done pulse 2 cycles after start; k_len=0 behaves as k_len=1.
- srst asserted during WRITE row 7 -> next cycle all outputs at reset values, no further wr_en; a new start runs a full clean job.

Source files
------------

// File: rtl/tpu_tile_ctrl.sv
// tpu_tile_ctrl
// Tile sequencer for the systolic array. It runs cfg_num_tiles tiles back to
// back. Each tile clears the accumulators, streams k_len read addresses,
// waits for the array to drain, then reads the accumulators out one row per
// cycle. Each row is quantized (round-half-up, arithmetic shift, saturation)
// and written to one of NUM_OUT_BANKS output banks, which rotate per tile.
//
// Ports
//   clk_i, srst_i        clock, synchronous active-high reset
//   start_i              start request, accepted only in IDLE
//   cfg_num_tiles_i      tiles per job      (sampled on accepted start)
//   cfg_k_len_i          LOAD cycles/tile   (0 runs as 1)
//   cfg_shift_i          quantization right shift
//   busy_o, done_o       job handshake
//   sram_raddr_o         shared operand read address, continuous across tiles
//   alu_clear_o          accumulator clear pulse at tile start
//   alu_start_o          high while the array consumes operands
//   row_sel_o, acc_data_i  accumulator row select / row contents (lane 0 LSBs)
//   wr_en_o, waddr_o, wdata_o  one-hot bank write of a quantized row
//   sat_count_o          saturated-lane counter (TPU_SAT_CNT_EN only)
//
// Build option: define TPU_SAT_CNT_EN to add sat_count_o.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// CLEAR  | accumulator clear pulse
// LOAD   | k_len cycles of operand streaming, address increments
// DRAIN  | 2*ARRAY_SIZE-1 cycles for the array pipeline to empty
// WRITE  | ARRAY_SIZE rows read out, each written one cycle later
// NEXT   | last row written, advance tile / bank
// FIN    | done pulse (an empty job spends one busy cycle here first)

module tpu_tile_ctrl #(
    parameter int ARRAY_SIZE        = 16,
    parameter int ACC_WIDTH         = 21,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int RADDR_WIDTH       = 10,
    parameter int WADDR_WIDTH       = 6,
    parameter int NUM_OUT_BANKS     = 3,
    parameter int TILE_WIDTH        = 4
) (
    input  logic                                    clk_i,
    input  logic                                    srst_i,
    input  logic                                    start_i,
    input  logic [TILE_WIDTH-1:0]                   cfg_num_tiles_i,
    input  logic [8:0]                              cfg_k_len_i,
    input  logic [4:0]                              cfg_shift_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic [RADDR_WIDTH-1:0]                  sram_raddr_o,
    output logic                                    alu_clear_o,
    output logic                                    alu_start_o,
    output logic [$clog2(ARRAY_SIZE)-1:0]           row_sel_o,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         acc_data_i,
    output logic [NUM_OUT_BANKS-1:0]                wr_en_o,
    output logic [WADDR_WIDTH-1:0]                  waddr_o,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wdata_o
`ifdef TPU_SAT_CNT_EN
    ,
    output logic [15:0]                             sat_count_o
`endif
);

    localparam int ROW_W  = $clog2(ARRAY_SIZE);
    localparam int CNT_W  = ($clog2(2*ARRAY_SIZE) > 9) ? $clog2(2*ARRAY_SIZE) : 9;
    localparam int BANK_W = (NUM_OUT_BANKS > 1) ? $clog2(NUM_OUT_BANKS) : 1;
    localparam logic signed [ACC_WIDTH:0] Q_MAX =
        (ACC_WIDTH+1)'((1 << (OUTPUT_DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] Q_MIN = ~Q_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_WRITE, S_NEXT, S_FIN
    } state_t;

    state_t                                  state_q;
    logic                                    busy_q, done_q, alu_clear_q, alu_start_q;
    logic [RADDR_WIDTH-1:0]                  raddr_q;
    logic [ROW_W-1:0]                        row_sel_q;
    logic [NUM_OUT_BANKS-1:0]                wr_en_q;
    logic [WADDR_WIDTH-1:0]                  waddr_q;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wdata_q;
    logic [TILE_WIDTH-1:0]                   num_tiles_q, tile_idx_q, group_q;
    logic [BANK_W-1:0]                       bank_q;
    logic [8:0]                              k_len_q;
    logic [4:0]                              shift_q;
    logic [CNT_W-1:0]                        cnt_q;

    logic signed [ACC_WIDTH:0]               rs_d;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quant_d;

    // Round-half-up then arithmetic shift, in ACC_WIDTH+1 bits so the
    // rounding add cannot overflow. Shifts past the accumulator width
    // collapse to the sign (0 or -1).
    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic [ACC_WIDTH-1:0] a,
        input logic [4:0]           sh
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        ext = $signed({a[ACC_WIDTH-1], a});
        if (int'(sh) >= ACC_WIDTH) begin
            return {(ACC_WIDTH+1){a[ACC_WIDTH-1]}};
        end
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = (ACC_WIDTH+1)'(1) << (sh - 5'd1);
        end
        return (ext + rnd) >>> sh;
    endfunction

`ifdef TPU_SAT_CNT_EN
    localparam int SAT_W = $clog2(ARRAY_SIZE+1);
    logic [SAT_W-1:0] sat_num_d;
    logic [16:0]      sat_sum_d;
    logic [15:0]      sat_cnt_q;
`endif

    always_comb begin
        quant_d = '0;
        rs_d    = '0;
`ifdef TPU_SAT_CNT_EN
        sat_num_d = '0;
`endif
        for (int l = 0; l < ARRAY_SIZE; l++) begin
            rs_d = round_shift(acc_data_i[l*ACC_WIDTH +: ACC_WIDTH], shift_q);
            if (rs_d > Q_MAX) begin
                quant_d[l*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = Q_MAX[OUTPUT_DATA_WIDTH-1:0];
`ifdef TPU_SAT_CNT_EN
                sat_num_d = sat_num_d + SAT_W'(1);
`endif
            end else if (rs_d < Q_MIN) begin
                quant_d[l*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = Q_MIN[OUTPUT_DATA_WIDTH-1:0];
`ifdef TPU_SAT_CNT_EN
                sat_num_d = sat_num_d + SAT_W'(1);
`endif
            end else begin
                quant_d[l*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = rs_d[OUTPUT_DATA_WIDTH-1:0];
            end
        end
    end

`ifdef TPU_SAT_CNT_EN
    assign sat_sum_d = {1'b0, sat_cnt_q} + 17'(sat_num_d);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sat_cnt_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            sat_cnt_q <= '0;
        end else if (state_q == S_WRITE) begin
            sat_cnt_q <= sat_sum_d[16] ? 16'hFFFF : sat_sum_d[15:0];
        end
    end

    assign sat_count_o = sat_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_clear_q <= 1'b0;
            alu_start_q <= 1'b0;
            raddr_q     <= '0;
            row_sel_q   <= '0;
            wr_en_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
            group_q     <= '0;
            bank_q      <= '0;
            k_len_q     <= 9'd1;
            shift_q     <= '0;
            cnt_q       <= '0;
        end else begin
            done_q      <= 1'b0;
            alu_clear_q <= 1'b0;
            wr_en_q     <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        num_tiles_q <= cfg_num_tiles_i;
                        k_len_q     <= (cfg_k_len_i == 9'd0) ? 9'd1 : cfg_k_len_i;
                        shift_q     <= cfg_shift_i;
                        tile_idx_q  <= '0;
                        group_q     <= '0;
                        bank_q      <= '0;
                        raddr_q     <= '0;
                        busy_q      <= 1'b1;
                        if (cfg_num_tiles_i == '0) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q     <= S_CLEAR;
                            alu_clear_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_q     <= S_LOAD;
                    alu_start_q <= 1'b1;
                    cnt_q       <= CNT_W'(k_len_q) - CNT_W'(1);
                end
                S_LOAD: begin
                    raddr_q <= raddr_q + RADDR_WIDTH'(1);
                    if (cnt_q == '0) begin
                        state_q     <= S_DRAIN;
                        alu_start_q <= 1'b0;
                        cnt_q       <= CNT_W'(2*ARRAY_SIZE-2);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_WRITE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    wr_en_q <= NUM_OUT_BANKS'(1) << bank_q;
                    waddr_q <= WADDR_WIDTH'(int'(group_q) * ARRAY_SIZE + int'(row_sel_q));
                    wdata_q <= quant_d;
                    if (row_sel_q == ROW_W'(ARRAY_SIZE-1)) begin
                        row_sel_q <= '0;
                        state_q   <= S_NEXT;
                    end else begin
                        row_sel_q <= row_sel_q + ROW_W'(1);
                    end
                end
                S_NEXT: begin
                    tile_idx_q <= tile_idx_q + TILE_WIDTH'(1);
                    // group_q tracks tile_idx / NUM_OUT_BANKS without a divider
                    if (bank_q == BANK_W'(NUM_OUT_BANKS-1)) begin
                        bank_q  <= '0;
                        group_q <= group_q + TILE_WIDTH'(1);
                    end else begin
                        bank_q <= bank_q + BANK_W'(1);
                    end
                    if (tile_idx_q + TILE_WIDTH'(1) == num_tiles_q) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_CLEAR;
                        alu_clear_q <= 1'b1;
                    end
                end
                S_FIN: begin
                    // Still busy means we arrived straight from IDLE (empty job)
                    if (busy_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sram_raddr_o = raddr_q;
    assign alu_clear_o  = alu_clear_q;
    assign alu_start_o  = alu_start_q;
    assign row_sel_o    = row_sel_q;
    assign wr_en_o      = wr_en_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;

endmodule
